button_debounce: RTL and testbench

- Conditions the raw, active-low, asynchronous push-button pins before the board-level logic uses them.
- Per button: 2-FF synchronizer, polarity inversion, counter-based debounce FSM.
- Outputs per button: a clean active-high level plus one-cycle press and release pulses.
- Sits directly upstream of the LED/application logic that consumes push_button0/push_button1.

---
 rtl/button_debounce.sv | 172 +++++++++++++++++
 tb/tb_button_debounce.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/button_debounce.sv
// button_debounce: per-channel 2-FF synchronizer, polarity inversion and counter debounce FSM
// for active-low push buttons. Optional long-press pulse: define BUTTON_DEBOUNCE_LONG_PRESS_EN.
module button_debounce #(
  parameter int NUM_BUTTONS       = 2,
  parameter int DEBOUNCE_CYCLES   = 250000,
  parameter int LONG_PRESS_CYCLES = 25000000
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_BUTTONS-1:0] push_button_n,
  output logic [NUM_BUTTONS-1:0] button_level,
  output logic [NUM_BUTTONS-1:0] button_press,
  output logic [NUM_BUTTONS-1:0] button_release,
  output logic [NUM_BUTTONS-1:0] button_long
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    RELEASED      = 2'd0,
    PRESS_CHECK   = 2'd1,
    PRESSED       = 2'd2,
    RELEASE_CHECK = 2'd3
  } state_e;

  if (NUM_BUTTONS < 1 || DEBOUNCE_CYCLES < 1 || LONG_PRESS_CYCLES < 1) begin : g_bad_params
    $error("button_debounce: all parameters must be >= 1");
  end

  logic [NUM_BUTTONS-1:0] sync1_q, sync2_q;
  logic [NUM_BUTTONS-1:0] raw_s;
  state_e                 state_q [NUM_BUTTONS];
  state_e                 state_d [NUM_BUTTONS];
  logic [CW-1:0]          cnt_q   [NUM_BUTTONS];
  logic [CW-1:0]          cnt_d   [NUM_BUTTONS];
  logic [NUM_BUTTONS-1:0] level_q, level_d;
  logic [NUM_BUTTONS-1:0] press_q, press_d;
  logic [NUM_BUTTONS-1:0] release_q, release_d;
  logic [NUM_BUTTONS-1:0] long_q, long_d;

  assign raw_s = ~sync2_q;

  // Debounce next-state: a level change is accepted only after an unbroken run of samples.
  always_comb begin
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      state_d[i]   = state_q[i];
      cnt_d[i]     = cnt_q[i];
      press_d[i]   = 1'b0;
      release_d[i] = 1'b0;
      case (state_q[i])
        RELEASED: begin
          cnt_d[i] = '0;
          if (raw_s[i]) state_d[i] = PRESS_CHECK;
          else          state_d[i] = RELEASED;
        end
        PRESS_CHECK: begin
          if (!raw_s[i]) begin
            state_d[i] = RELEASED;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i] = PRESSED;
            cnt_d[i]   = '0;
            press_d[i] = 1'b1;
          end else begin
            cnt_d[i]   = cnt_q[i] + CW'(1);
          end
        end
        PRESSED: begin
          cnt_d[i] = '0;
          if (!raw_s[i]) state_d[i] = RELEASE_CHECK;
          else           state_d[i] = PRESSED;
        end
        RELEASE_CHECK: begin
          if (raw_s[i]) begin
            state_d[i]   = PRESSED;
            cnt_d[i]     = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i]   = RELEASED;
            cnt_d[i]     = '0;
            release_d[i] = 1'b1;
          end else begin
            cnt_d[i]     = cnt_q[i] + CW'(1);
          end
        end
        default: begin
          state_d[i] = RELEASED;
          cnt_d[i]   = '0;
        end
      endcase
      level_d[i] = (state_d[i] == PRESSED) || (state_d[i] == RELEASE_CHECK);
    end
  end

  // Synchronizers, FSM state and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q   <= '1;
      sync2_q   <= '1;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      long_q    <= '0;
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        state_q[i] <= RELEASED;
        cnt_q[i]   <= '0;
      end
    end else begin
      sync1_q   <= push_button_n;
      sync2_q   <= sync1_q;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
  localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_SAT  = HW'(LONG_PRESS_CYCLES);

  logic [HW-1:0] hold_q [NUM_BUTTONS];
  logic [HW-1:0] hold_d [NUM_BUTTONS];

  // Hold timer restarts on an accepted press only, so a release bounce cannot re-arm it.
  always_comb begin
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      hold_d[i] = '0;
      long_d[i] = 1'b0;
      if (press_d[i]) begin
        hold_d[i] = '0;
      end else if (level_q[i] && !release_d[i]) begin
        if (hold_q[i] == HOLD_LAST) begin
          hold_d[i] = HOLD_SAT;
          long_d[i] = 1'b1;
        end else if (hold_q[i] == HOLD_SAT) begin
          hold_d[i] = HOLD_SAT;
        end else begin
          hold_d[i] = hold_q[i] + HW'(1);
        end
      end else begin
        hold_d[i] = '0;
      end
    end
  end

  // Hold counter registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_BUTTONS; i++) hold_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_BUTTONS; i++) hold_q[i] <= hold_d[i];
    end
  end
`else
  // Long-press feature compiled out.
  always_comb begin
    long_d = '0;
  end
`endif

  assign button_level   = level_q;
  assign button_press   = press_q;
  assign button_release = release_q;
  assign button_long    = long_q;

endmodule

// File: tb/tb_button_debounce.sv
// Self-checking bench for button_debounce: directed scenarios plus random pin activity,
// compared against a run-length behavioural model of the debounce rules.
module tb_button_debounce;

  localparam int N = 2;
  localparam int D = 4;
  localparam int L = 20;
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  logic         clock;
  logic         reset;
  logic [N-1:0] push_button_n;
  logic [N-1:0] button_level, button_press, button_release, button_long;

  button_debounce #(
    .NUM_BUTTONS(N), .DEBOUNCE_CYCLES(D), .LONG_PRESS_CYCLES(L)
  ) dut (
    .clock(clock), .reset(reset), .push_button_n(push_button_n),
    .button_level(button_level), .button_press(button_press),
    .button_release(button_release), .button_long(button_long)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_asserts = 0;
  int n_fails   = 0;

  // Reference model: pins pass through a 2-sample delay; the accepted level flips once the
  // synchronized value has disagreed with it for D+1 consecutive samples.
  logic [N-1:0] m_s1, m_s2, m_level, m_press, m_rel, m_long;
  int m_run [N];
  int m_age [N];
  bit m_fired [N];

  // Event bookkeeping for directed scenarios.
  int edge_idx;
  int press_cnt [N];
  int rel_cnt   [N];
  int long_cnt  [N];
  int press_edge [N];
  int rel_edge   [N];
  int long_edge  [N];
  bit saw_both_press, saw_both_rel;

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_asserts++;
    assert (obs == exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_update(input logic [N-1:0] pins, input logic rst);
    logic [N-1:0] raw;
    raw = ~m_s2;
    m_press = '0;
    m_rel   = '0;
    m_long  = '0;
    if (rst) begin
      m_s1 = '1;
      m_s2 = '1;
      m_level = '0;
      for (int i = 0; i < N; i++) begin
        m_run[i] = 0; m_age[i] = 0; m_fired[i] = 1'b1;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (raw[i] != m_level[i]) m_run[i]++;
        else                      m_run[i] = 0;
        if (m_level[i] && m_run[i] != D + 1) begin
          m_age[i]++;
          if (LONG_EN && m_age[i] == L && !m_fired[i]) begin
            m_long[i]  = 1'b1;
            m_fired[i] = 1'b1;
          end
        end
        if (m_run[i] == D + 1) begin
          if (m_level[i]) m_rel[i] = 1'b1;
          else begin
            m_press[i] = 1'b1;
            m_age[i]   = 0;
            m_fired[i] = 1'b0;
          end
          m_level[i] = ~m_level[i];
          m_run[i]   = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = pins;
    end
  endtask

  task automatic clear_ev();
    edge_idx = 0;
    saw_both_press = 1'b0;
    saw_both_rel   = 1'b0;
    for (int i = 0; i < N; i++) begin
      press_cnt[i] = 0; rel_cnt[i] = 0; long_cnt[i] = 0;
      press_edge[i] = -1; rel_edge[i] = -1; long_edge[i] = -1;
    end
  endtask

  task automatic step(input logic [N-1:0] pins, input logic rst);
    push_button_n = pins;
    reset = rst;
    @(posedge clock);
    model_update(pins, rst);
    #1;
    chk("level",   button_level,   m_level);
    chk("press",   button_press,   m_press);
    chk("release", button_release, m_rel);
    chk("long",    button_long,    m_long);
    for (int i = 0; i < N; i++) begin
      if (button_press[i])   begin press_cnt[i]++; press_edge[i] = edge_idx; end
      if (button_release[i]) begin rel_cnt[i]++;   rel_edge[i]   = edge_idx; end
      if (button_long[i])    begin long_cnt[i]++;  long_edge[i]  = edge_idx; end
    end
    if (button_press === 2'b11)   saw_both_press = 1'b1;
    if (button_release === 2'b11) saw_both_rel   = 1'b1;
    edge_idx++;
  endtask

  task automatic hold(input logic [N-1:0] pins, input int cycles);
    for (int k = 0; k < cycles; k++) step(pins, 1'b0);
  endtask

  initial begin
    logic [N-1:0] rpins;
    int seg;
    push_button_n = '1;
    reset = 1'b1;
    clear_ev();
    for (int k = 0; k < 3; k++) step(2'b11, 1'b1);
    chk("reset_outputs", button_level | button_press | button_release | button_long, 2'b00);
    hold(2'b11, 5);

    // Clean press on channel 0.
    clear_ev();
    hold(2'b10, 10);
    chk_int("clean_press_edge", press_edge[0], 6);
    chk_int("clean_press_count", press_cnt[0], 1);
    chk_int("clean_press_ch1", press_cnt[1], 0);
    chk("clean_press_level", button_level, 2'b01);

    // Release with a short glitch back low.
    hold(2'b11, 2);
    hold(2'b10, 1);
    clear_ev();
    hold(2'b11, 10);
    chk_int("glitch_release_edge", rel_edge[0], 6);
    chk_int("glitch_release_count", rel_cnt[0], 1);
    chk_int("glitch_release_no_press", press_cnt[0], 0);

    // Bounce rejection then a stable press.
    clear_ev();
    hold(2'b10, 3);
    hold(2'b11, 2);
    hold(2'b10, 3);
    hold(2'b11, 6);
    chk_int("bounce_no_press", press_cnt[0], 0);
    chk("bounce_level", button_level, 2'b00);
    clear_ev();
    hold(2'b10, 10);
    chk_int("bounce_then_press_edge", press_edge[0], 6);
    chk_int("bounce_then_press_count", press_cnt[0], 1);
    hold(2'b11, 12);

    // Simultaneous channels.
    clear_ev();
    hold(2'b00, 10);
    chk_int("simul_press_edge0", press_edge[0], 6);
    chk_int("simul_press_edge1", press_edge[1], 6);
    chk_int("simul_press_same_cycle", int'(saw_both_press), 1);
    clear_ev();
    hold(2'b11, 10);
    chk_int("simul_release_edge0", rel_edge[0], 6);
    chk_int("simul_release_edge1", rel_edge[1], 6);
    chk_int("simul_release_same_cycle", int'(saw_both_rel), 1);

    // Reset while held in PRESSED.
    hold(2'b10, 10);
    chk("pre_reset_level", button_level, 2'b01);
    step(2'b10, 1'b1);
    chk("in_reset_outputs", button_level | button_press | button_release | button_long, 2'b00);
    step(2'b10, 1'b1);
    chk("in_reset_outputs2", button_level | button_press | button_release | button_long, 2'b00);
    clear_ev();
    hold(2'b10, 10);
    chk_int("post_reset_press_edge", press_edge[0], 6);
    chk_int("post_reset_press_count", press_cnt[0], 1);
    hold(2'b11, 12);

    // Long hold, then a short hold.
    clear_ev();
    hold(2'b10, 46);
    chk_int("long_hold_count", long_cnt[0], LONG_EN ? 1 : 0);
    chk_int("long_hold_edge", long_edge[0], LONG_EN ? 6 + L : -1);
    hold(2'b11, 12);
    clear_ev();
    hold(2'b10, 15);
    hold(2'b11, 12);
    chk_int("short_hold_press", press_cnt[0], 1);
    chk_int("short_hold_no_long", long_cnt[0], 0);

    // Random pin activity with occasional resets.
    for (int s = 0; s < 60; s++) begin
      rpins = N'($urandom_range(0, 3));
      seg = $urandom_range(1, 12);
      for (int k = 0; k < seg; k++) step(rpins, ($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0);
    end
    hold(2'b11, 12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
